// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters, with burst ownership and a beat cap.
// Latency: grant and SRAM drive are combinational in the request cycle; read data is returned one cycle later.
// Backpressure: a refused requester holds req_valid until req_ready; bursts rotate after MAX_BURST beats or a valid drop.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_REQ    = 3,
    parameter int MAX_BURST  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             sram_en,
    output logic                             sram_we,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [DATA_WIDTH-1:0]            sram_wdata,
    input  logic [DATA_WIDTH-1:0]            sram_rdata,
    output logic [1:0]                       grant_id,
    input  logic                             stall_clr,
    output logic [15:0]                      stall_cnt
);

    localparam logic [0:0] ST_ARB = 1'b0;
    localparam logic [0:0] ST_OWN = 1'b1;
    localparam logic       BURST_EN = (MAX_BURST > 1);

    logic [0:0]            state_q, state_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [1:0]            owner_q, owner_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [1:0]            grant_id_q;
    logic [15:0]           stall_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [DATA_WIDTH-1:0] wdata_hold_q;

    logic                  gnt_vld;
    logic [1:0]            gnt_idx;
    logic [1:0]            cand;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  stall_hit;

    // Index of the next requester, wrapping at NUM_REQ.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        if (int'(i) == NUM_REQ - 1) return 2'd0;
        return i + 2'd1;
    endfunction

    // Pick the granted requester: owner during a burst, else first valid from rr_ptr upward.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = owner_q;
        cand      = rr_ptr_q;
        req_ready = '0;
        if (!rst) begin
            if (state_q == ST_OWN) begin
                gnt_vld = req_valid[owner_q];
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!gnt_vld && req_valid[cand]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = cand;
                    end
                    cand = next_idx(cand);
                end
            end
            if (gnt_vld) req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sram_en    = |(req_valid & req_ready);
    assign sram_we    = sram_en & req_we[gnt_idx];
    // Address and data hold their last driven value while the SRAM is idle.
    assign sram_addr  = sram_en ? sel_addr  : addr_hold_q;
    assign sram_wdata = sram_en ? sel_wdata : wdata_hold_q;
    assign stall_hit  = |(req_valid & ~req_ready);

    // Burst ownership and round-robin pointer next-state.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == ST_ARB) begin
            if (gnt_vld) begin
                if (!req_last[gnt_idx] && BURST_EN) begin
                    state_d    = ST_OWN;
                    owner_d    = gnt_idx;
                    beat_cnt_d = 8'd1;
                end else begin
                    rr_ptr_d = next_idx(gnt_idx);
                end
            end
        end else begin
            // Dropping valid, ending the burst, or hitting the cap all hand the port on.
            if (!req_valid[owner_q] || req_last[owner_q] ||
                (int'(beat_cnt_q) + 1 == MAX_BURST)) begin
                state_d    = ST_ARB;
                rr_ptr_d   = next_idx(owner_q);
                beat_cnt_d = 8'd0;
            end else begin
                beat_cnt_d = beat_cnt_q + 8'd1;
            end
        end
    end

    // State, response tagging, grant record, stall counter and idle-hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ARB;
            rr_ptr_q     <= 2'd0;
            owner_q      <= 2'd0;
            beat_cnt_q   <= 8'd0;
            rsp_valid_q  <= '0;
            grant_id_q   <= 2'd0;
            stall_cnt_q  <= 16'd0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_valid_q <= (sram_en && !sram_we) ? req_ready : '0;
            if (sram_en) begin
                grant_id_q   <= gnt_idx;
                addr_hold_q  <= sel_addr;
                wdata_hold_q <= sel_wdata;
            end
            if (stall_clr)
                stall_cnt_q <= 16'd0;
            else if (stall_hit && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = sram_rdata;
    assign grant_id  = grant_id_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural 1-cycle SRAM.
// Read responses are predicted into a queue when a beat is expected to be accepted.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_sram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NR = 3;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NR-1:0] req_valid, req_we, req_last, req_ready, rsp_valid;
    logic [AW-1:0] a  [NR];
    logic [DW-1:0] wd [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, sram_wdata, sram_rdata;
    logic          sram_en, sram_we, stall_clr;
    logic [AW-1:0] sram_addr;
    logic [1:0]    grant_id;
    logic [15:0]   stall_cnt;

    assign req_addr  = {a[2], a[1], a[0]};
    assign req_wdata = {wd[2], wd[1], wd[0]};

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .grant_id(grant_id),
        .stall_clr(stall_clr), .stall_cnt(stall_cnt)
    );

    // Behavioural scratchpad and an independent reference copy.
    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] ref_mem [1024];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    typedef struct { int due; logic [NR-1:0] id; logic [DW-1:0] data; } rsp_t;
    rsp_t exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every cycle either the predicted response or silence.
    always @(negedge clk) begin
        rsp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            compared++;
            if (rsp_valid !== e.id || rsp_rdata !== e.data) begin
                mismatched++;
                $display("FAIL rsp cyc%0d: got valid=%b data=%h, expected valid=%b data=%h",
                         cyc, rsp_valid, rsp_rdata, e.id, e.data);
            end
        end else begin
            compared++;
            if (rsp_valid !== '0) begin
                mismatched++;
                $display("FAIL rsp_idle cyc%0d: got valid=%b, expected 000", cyc, rsp_valid);
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Apply the bench's expected acceptance to the reference memory and response queue.
    task automatic accept(input logic [NR-1:0] rdy);
        rsp_t e;
        for (int i = 0; i < NR; i++) begin
            if (rdy[i]) begin
                if (req_we[i]) ref_mem[a[i]] = wd[i];
                else begin
                    e.due  = cyc + 1;
                    e.id   = NR'(1) << i;
                    e.data = ref_mem[a[i]];
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 3'b111; req_last = 3'b111; req_we = 3'b000;
        @(negedge clk);
        compared++; if (req_ready !== 3'b000) begin mismatched++; $display("FAIL rst_ready: got %b expected 000", req_ready); end
        compared++; if (sram_en !== 1'b0) begin mismatched++; $display("FAIL rst_sram_en: got %b expected 0", sram_en); end
        adv();
        @(negedge clk);
        compared++; if (grant_id !== 2'd0) begin mismatched++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
        compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt); end
        req_valid = 3'b000;
        adv();
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        a[0] = 10; a[1] = 20; a[2] = 30; req_last = 3'b111; req_we = 3'b000;
        req_valid = 3'b111;
        @(negedge clk);
        compared++; if (req_ready !== 3'b001) begin mismatched++; $display("FAIL sim_c1_ready: got %b expected 001", req_ready); end
        accept(3'b001); adv();
        req_valid = 3'b110;
        @(negedge clk);
        compared++; if (req_ready !== 3'b010) begin mismatched++; $display("FAIL sim_c2_ready: got %b expected 010", req_ready); end
        compared++; if (grant_id !== 2'd0) begin mismatched++; $display("FAIL sim_c2_gid: got %0d expected 0", grant_id); end
        accept(3'b010); adv();
        req_valid = 3'b100;
        @(negedge clk);
        compared++; if (req_ready !== 3'b100) begin mismatched++; $display("FAIL sim_c3_ready: got %b expected 100", req_ready); end
        compared++; if (grant_id !== 2'd1) begin mismatched++; $display("FAIL sim_c3_gid: got %0d expected 1", grant_id); end
        accept(3'b100); adv();
        req_valid = 3'b000;
        @(negedge clk);
        compared++; if (stall_cnt !== 16'd2) begin mismatched++; $display("FAIL sim_stall: got %0d expected 2", stall_cnt); end
        compared++; if (grant_id !== 2'd2) begin mismatched++; $display("FAIL sim_c4_gid: got %0d expected 2", grant_id); end
        adv();
    endtask

    task automatic test_write_read();
        a[0] = 0; wd[0] = 32'h0202_0202; req_we = 3'b001; req_last = 3'b111; req_valid = 3'b001;
        @(negedge clk);
        compared++; if (req_ready !== 3'b001) begin mismatched++; $display("FAIL wr_ready: got %b expected 001", req_ready); end
        compared++; if ({sram_en, sram_we} !== 2'b11) begin mismatched++; $display("FAIL wr_en_we: got %b expected 11", {sram_en, sram_we}); end
        compared++; if (sram_addr !== 10'd0 || sram_wdata !== 32'h0202_0202) begin mismatched++; $display("FAIL wr_bus: got addr=%0d data=%h expected 0 02020202", sram_addr, sram_wdata); end
        accept(3'b001); adv();
        req_we = 3'b000; a[1] = 0; req_valid = 3'b010;
        @(negedge clk);
        compared++; if (req_ready !== 3'b010) begin mismatched++; $display("FAIL rd_ready: got %b expected 010", req_ready); end
        compared++; if ({sram_en, sram_we} !== 2'b10) begin mismatched++; $display("FAIL rd_en_we: got %b expected 10", {sram_en, sram_we}); end
        accept(3'b010); adv();
        req_valid = 3'b000;
        @(negedge clk);
        compared++; if (sram_en !== 1'b0) begin mismatched++; $display("FAIL wr_rd_idle: got %b expected 0", sram_en); end
        adv();
    endtask

    task automatic test_burst_cap();
        logic [NR-1:0] exp_tab [11];
        int k;
        bit r0done;
        exp_tab = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010,
                    3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
        k = 0; r0done = 0;
        req_we = 3'b000; a[0] = 5;
        for (int c = 0; c < 11; c++) begin
            req_valid[1] = (k < 10);
            a[1]         = AW'(512 + k);
            req_last[1]  = (k == 9);
            req_valid[0] = (c >= 1) && !r0done;
            req_last[0]  = 1'b1;
            req_valid[2] = 1'b0;
            @(negedge clk);
            compared++;
            if (req_ready !== exp_tab[c]) begin
                mismatched++;
                $display("FAIL burst_c%0d_ready: got %b expected %b", c, req_ready, exp_tab[c]);
            end
            accept(exp_tab[c]);
            if (exp_tab[c][1]) k++;
            if (exp_tab[c][0]) r0done = 1;
            adv();
        end
        req_valid = 3'b000; req_last = 3'b111;
    endtask

    task automatic test_owner_drop();
        req_we = 3'b100; req_last = 3'b011; a[2] = 100; wd[2] = 32'hD00D_0001; req_valid = 3'b100;
        @(negedge clk);
        compared++; if (req_ready !== 3'b100) begin mismatched++; $display("FAIL drop_c1_ready: got %b expected 100", req_ready); end
        accept(3'b100); adv();
        a[2] = 101; wd[2] = 32'hD00D_0002;
        @(negedge clk);
        compared++; if (req_ready !== 3'b100) begin mismatched++; $display("FAIL drop_c2_ready: got %b expected 100", req_ready); end
        accept(3'b100); adv();
        req_valid = 3'b011; a[0] = 7; a[1] = 8;
        @(negedge clk);
        compared++; if (req_ready !== 3'b000) begin mismatched++; $display("FAIL drop_bubble_ready: got %b expected 000", req_ready); end
        compared++; if ({sram_en, sram_we} !== 2'b00 || sram_addr !== 10'd101) begin mismatched++; $display("FAIL drop_bubble_bus: got en/we=%b addr=%0d expected 00 101", {sram_en, sram_we}, sram_addr); end
        compared++; if (grant_id !== 2'd2) begin mismatched++; $display("FAIL drop_gid_hold: got %0d expected 2", grant_id); end
        adv();
        @(negedge clk);
        compared++; if (req_ready !== 3'b001) begin mismatched++; $display("FAIL drop_next_ready: got %b expected 001", req_ready); end
        accept(3'b001); adv();
        req_valid = 3'b010;
        @(negedge clk);
        compared++; if (req_ready !== 3'b010) begin mismatched++; $display("FAIL drop_req1_ready: got %b expected 010", req_ready); end
        accept(3'b010); adv();
        req_valid = 3'b000; req_we = 3'b000;
    endtask

    task automatic test_reset_mid_burst();
        req_last = 3'b011; a[2] = 700; req_valid = 3'b100;
        @(negedge clk);
        compared++; if (req_ready !== 3'b100) begin mismatched++; $display("FAIL rmb_b1_ready: got %b expected 100", req_ready); end
        accept(3'b100); adv();
        a[2] = 701;
        @(negedge clk);
        compared++; if (req_ready !== 3'b100) begin mismatched++; $display("FAIL rmb_b2_ready: got %b expected 100", req_ready); end
        accept(3'b100); adv();
        a[2] = 702; a[0] = 9; req_valid = 3'b101; rst = 1'b1;
        @(negedge clk);
        compared++; if (req_ready !== 3'b000 || sram_en !== 1'b0) begin mismatched++; $display("FAIL rmb_b3: got ready=%b en=%b expected 000 0", req_ready, sram_en); end
        adv();
        @(negedge clk);
        compared++; if (req_ready !== 3'b000 || sram_en !== 1'b0) begin mismatched++; $display("FAIL rmb_hold: got ready=%b en=%b expected 000 0", req_ready, sram_en); end
        adv();
        rst = 1'b0;
        @(negedge clk);
        compared++; if (req_ready !== 3'b001) begin mismatched++; $display("FAIL rmb_first_grant: got %b expected 001", req_ready); end
        compared++; if (stall_cnt !== 16'd0 || grant_id !== 2'd0) begin mismatched++; $display("FAIL rmb_regs: got stall=%0d gid=%0d expected 0 0", stall_cnt, grant_id); end
        accept(3'b001); adv();
        req_valid = 3'b000; req_last = 3'b111;
        adv();
    endtask

    task automatic test_saturation();
        req_we = 3'b011; req_last = 3'b000; a[0] = 900; a[1] = 901;
        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
        req_valid = 3'b011; stall_clr = 1'b1;
        adv();
        stall_clr = 1'b0;
        @(negedge clk);
        compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL sat_clr0: got %0d expected 0", stall_cnt); end
        repeat (10) adv();
        @(negedge clk);
        compared++; if (stall_cnt !== 16'd10) begin mismatched++; $display("FAIL sat_count10: got %0d expected 10", stall_cnt); end
        repeat (65530) adv();
        @(negedge clk);
        compared++; if (stall_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_max: got %h expected ffff", stall_cnt); end
        adv();
        stall_clr = 1'b1;
        adv();
        stall_clr = 1'b0;
        @(negedge clk);
        compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL sat_clear: got %0d expected 0", stall_cnt); end
        adv();
        @(negedge clk);
        compared++; if (stall_cnt !== 16'd1) begin mismatched++; $display("FAIL sat_recount: got %0d expected 1", stall_cnt); end
        req_valid = 3'b000; req_we = 3'b000; req_last = 3'b111;
        adv();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hC0DE_0000 + i;
            ref_mem[i] = 32'hC0DE_0000 + i;
        end
        rst = 1'b1; stall_clr = 1'b0;
        req_valid = '0; req_we = '0; req_last = '1;
        for (int i = 0; i < NR; i++) begin a[i] = '0; wd[i] = '0; end
        adv();
        test_reset();
        test_simultaneous();
        test_write_read();
        test_burst_cap();
        test_owner_drop();
        test_reset_mid_burst();
        test_saturation();
        repeat (2) adv();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL rsp_pending: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port scratchpad SRAM (sram_scratchpad, 1-cycle read latency) between NUM_REQ requesters: host DMA backdoor (req 0), compute controller/PE-array operand fetch (req 1) and AXI-lite result readback (req 2).
- Round-robin arbitration with burst ownership and a hard burst-length cap, so a long weight/activation stream cannot starve the other requesters.
- Returns read data tagged to the issuing requester.
- Sits between the requesters and each u_sram_* instance in accelerator_soc; one instance per SRAM.

Parameters:
- DATA_WIDTH, 32, SRAM word width.
- ADDR_WIDTH, 10, SRAM word address width.
- NUM_REQ, 3, number of requesters (2..4).
- MAX_BURST, 16, maximum beats per ownership before forced rotation (1..255).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle.
- req_we  in  NUM_REQ  1 = write beat, 0 = read beat.
- req_last  in  NUM_REQ  beat ends the requester's burst.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- rsp_valid  out  NUM_REQ  one-hot read-data valid.
- rsp_rdata  out  DATA_WIDTH  read data, meaningful only while rsp_valid != 0.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_wdata  out  DATA_WIDTH  SRAM write data.
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read.
- grant_id  out  2  index of the current or last granted requester.
- stall_clr  in  1  clears stall_cnt.
- stall_cnt  out  16  saturating count of cycles with at least one refused valid.

Behaviour:
- Reset (rst = 1 at a clk edge): state = ARB, rr_ptr = 0, owner = 0, beat_cnt = 0, rsp_valid = 0, grant_id = 0, stall_cnt = 0.
- While in reset, req_ready = 0 and sram_en = 0.
- Reset mid-burst abandons the burst. Any read issued in the reset cycle produces no rsp_valid.
- States: ARB (no owner) and OWN (burst owned by `owner`).
- ARB: grant the first requester with req_valid = 1, searching from rr_ptr upward modulo NUM_REQ. req_ready[g] = 1 in the same cycle, combinationally, and the beat is accepted.
  - If req_last[g] = 0 and MAX_BURST > 1: next state OWN, owner = g, beat_cnt = 1.
  - Otherwise: stay in ARB, rr_ptr = g + 1.
  - No valid requester: no grant, no state change.
- OWN: req_ready[owner] = req_valid[owner]; all other ready bits = 0.
  - Accepted beat with req_last = 1, or beat_cnt + 1 = MAX_BURST: next state ARB, rr_ptr = owner + 1 (forced rotation; the requester re-arbitrates for the rest of its burst).
  - Otherwise beat_cnt increments.
  - req_valid[owner] = 0 in OWN: release the burst; next state ARB, rr_ptr = owner + 1. This costs a one-cycle grant bubble.
- SRAM drive (combinational from the granted requester):
  - sram_en = |(req_valid & req_ready); sram_we = granted req_we; sram_addr and sram_wdata taken from the granted requester's fields.
  - When sram_en = 0: sram_we = 0; address and data hold their last value.
- Read response: an accepted read beat at cycle t gives rsp_valid = one-hot(g) registered at t+1, and rsp_rdata = sram_rdata at t+1 (pass-through).
  - Write beats never assert rsp_valid.
  - Back-to-back reads give back-to-back responses at full throughput, one beat per cycle.
- Ordering: accesses reach the SRAM in acceptance order. A read after a write to the same address by another requester, accepted in a later cycle, returns the new data.
- grant_id registers the index g of each accepted beat and holds between grants.
- stall_cnt:
  - Increments when (req_valid & ~req_ready) != 0 and rst = 0.
  - Saturates at 0xFFFF.
  - stall_clr = 1 zeroes it next cycle and has priority over increment.
- Requests with NUM_REQ index >= NUM_REQ do not exist; rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Single write then read: req0 writes 0x02020202 to addr 0 with last = 1, then req1 reads addr 0 → req_ready same cycle for each; rsp_valid = 3'b010 one cycle after the read, with rsp_rdata = 0x02020202.
- Simultaneous single beats, all last = 1, valid on req0/1/2 from reset → grants in order 0, 1, 2 on consecutive cycles; stall_cnt = 2 after the third cycle (req0 waits 0 cycles, req1 waits 1, req2 waits 2).
- Burst cap, MAX_BURST = 4: req1 issues a 10-beat read burst from addr 512 with req0 also valid → req1 gets 4 beats, req0 gets 1, then req1 gets 4 more; rsp_valid sequencing matches, and rsp_rdata equals the values at addr 512+k.
- Owner drop: req2 deasserts valid after 2 beats of a burst with last = 0 → one bubble cycle with sram_en = 0, state returns to ARB, and the next grant goes to req0 if it is valid.
- Reset mid-burst: assert rst during beat 3 of a read burst → following cycle rsp_valid = 0 and req_ready = 0; after release the first grant goes to req0 (rr_ptr = 0).
- Saturation and clear: hold req0 and req1 in contention for more than 65535 stalled cycles → stall_cnt = 0xFFFF; pulse stall_clr → 0 next cycle even with contention still present.
